// File: rtl/coso_beat_sampler.sv
// Purpose: measures clk cycles between debounced rising beat edges of osc_in sampled by clk.
// Latency: osc_in rise sampled -> sample loaded on the following clk edge (beat0 FF + edge capture).
// Backpressure: valid/ready; a sample arriving while one is held unconsumed is dropped and flags overflow.
module coso_beat_sampler #(
    parameter int CNT_WIDTH = 16,
    parameter int DEBOUNCE  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 osc_in,
    output logic [CNT_WIDTH-1:0] cnt_out,
    output logic                 bit_out,
    output logic                 sat_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        COUNT = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] DEB_MIN = CNT_WIDTH'(DEBOUNCE);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 beat0;
    logic                 beat1;
    logic                 beat_edge;
    logic                 cnt_sat;
    logic                 accept;

    // Single sampling flop is the entropy source; a synchroniser would filter out the jitter we want.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat0 <= 1'b0;
            beat1 <= 1'b0;
        end else begin
            beat0 <= osc_in;
            beat1 <= beat0;
        end
    end

    assign beat_edge = beat0 & ~beat1;
    assign cnt_sat   = &cnt;
    assign accept    = en && (state == COUNT) && beat_edge && (cnt >= DEB_MIN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cnt_out  <= '0;
            bit_out  <= 1'b0;
            sat_out  <= 1'b0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else if (!en) begin
            state    <= IDLE;
            cnt      <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= SYNC;
                    cnt      <= '0;
                    valid    <= 1'b0;
                    overflow <= 1'b0;
                end
                SYNC: begin
                    if (beat_edge) begin
                        cnt   <= CNT_ONE;
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    // Rejected glitch edges fall through here, so the period keeps accumulating.
                    if (accept) begin
                        cnt <= CNT_ONE;
                    end else if (!cnt_sat) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                if (!valid || ready) begin
                    cnt_out <= cnt;
                    bit_out <= cnt[0];
                    sat_out <= cnt_sat;
                    valid   <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
